// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI slave with a runtime-selectable mode (cpol/cpha) and bit order (lsbfe).
// All SPI pins are asynchronous to clk and are resynchronised before use.
// Everything runs on the single clk domain. A single-entry TX holding register
// feeds the TX shift register. Received words are presented on rx_data with a
// one-cycle rx_valid pulse.
//
// Optional feature macro: SPI_SLAVE_STATUS_EN
//   defined   -> tx_underrun / frame_err status pulses are generated
//   undefined -> tx_underrun / frame_err are tied to 0
//
// Parameters
//   DATA_BITS    bits per SPI word
//   SYNC_STAGES  synchroniser depth on sck/ss_n/mosi (>= 2)
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   cpol, cpha, lsbfe  SPI mode and bit order (static while selected)
//   sck, ss_n, mosi    SPI inputs from the master (asynchronous)
//   miso, miso_oe      SPI output and its drive enable
//   tx_data/valid/ready  write side of the TX holding register
//   rx_data, rx_valid  last complete received word, one-cycle update pulse
//   busy               frame in progress (FSM in ACTIVE)
//   tx_underrun        all-ones fill used because holding register was empty
//   frame_err          slave deselected in the middle of a word
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 lsbfe,
    input  logic                 sck,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 tx_underrun,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(DATA_BITS);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   ss_d;

    logic sck_s;
    logic ss_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic ss_fall;
    logic ss_rise;

    logic enter;
    logic leave;
    logic active;
    logic word_end;
    logic reload;
    logic shift_now;
    logic capture;
    logic pop;

    logic                 hold_full;
    logic [DATA_BITS-1:0] hold_data;
    logic [DATA_BITS-1:0] tx_shift;
    logic [DATA_BITS-1:0] rx_shift;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 word_done;
    logic                 first_edge;

    // Synchronisers plus one extra delayed copy of sck/ss_n for edge detection.
    // Everything resets to 1 so a reset never looks like a slave-select.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '1;
            ss_sync   <= '1;
            mosi_sync <= '1;
            sck_d     <= 1'b1;
            ss_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Leading edge leaves the idle level, trailing edge returns to it; cpha
    // picks which of the two samples mosi and which moves miso.
    assign sck_rise    = sck_s & ~sck_d;
    assign sck_fall    = ~sck_s & sck_d;
    assign lead_edge   = cpol ? sck_fall : sck_rise;
    assign trail_edge  = cpol ? sck_rise : sck_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_s & ss_d;
    assign ss_rise     = ss_s & ~ss_d;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state, with frame entry/exit strobes.
    always_comb begin
        state_next = state;
        enter      = 1'b0;
        leave      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = ACTIVE;
                    enter      = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_next = IDLE;
                    leave      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign active   = (state == ACTIVE);
    assign word_end = active && (bit_cnt == WORD_LEN);

    // The TX shift register is reloaded at frame entry and on the first shift
    // edge after a completed word. With cpha=1 the very first leading edge of a
    // frame only opens bit 0, which is already on miso, so it must not shift.
    assign reload    = enter | (active & shift_edge & word_done);
    assign shift_now = active & shift_edge & ~word_done & ~(cpha & first_edge);
    assign capture   = tx_valid & ~hold_full;
    assign pop       = reload & hold_full;

    // Holding register and TX shift register. A capture can only happen while
    // the holding register is empty, so a same-cycle reload sees the old
    // (empty) entry and falls back to the all-ones fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            tx_shift  <= '1;
        end else begin
            if (capture) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end else if (pop) begin
                hold_full <= 1'b0;
            end

            if (reload) begin
                tx_shift <= hold_full ? hold_data : '1;
            end else if (shift_now) begin
                if (lsbfe) begin
                    tx_shift <= {1'b1, tx_shift[DATA_BITS-1:1]};
                end else begin
                    tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b1};
                end
            end
        end
    end

    // Word-boundary bookkeeping for the TX side.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_done  <= 1'b0;
            first_edge <= 1'b0;
        end else if (enter) begin
            word_done  <= 1'b0;
            first_edge <= 1'b1;
        end else if (active) begin
            if (word_end) begin
                word_done <= 1'b1;
            end else if (shift_edge) begin
                word_done <= 1'b0;
            end
            if (shift_edge) begin
                first_edge <= 1'b0;
            end
        end
    end

    // Receive path. A partial word at deselect is dropped simply by clearing
    // the counter; rx_data keeps the previous complete word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift <= '1;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= word_end;
            if (word_end) begin
                rx_data <= rx_shift;
            end
            if (enter || leave || word_end) begin
                bit_cnt <= '0;
            end else if (active && sample_edge) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (lsbfe) begin
                    rx_shift <= {mosi_s, rx_shift[DATA_BITS-1:1]};
                end else begin
                    rx_shift <= {rx_shift[DATA_BITS-2:0], mosi_s};
                end
            end
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic underrun_q;
    logic frame_err_q;

    // Status pulses: empty-fill on reload, deselect with a partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            underrun_q  <= reload & ~hold_full;
            frame_err_q <= leave && (bit_cnt != '0) && !word_end;
        end
    end

    assign tx_underrun = underrun_q;
    assign frame_err   = frame_err_q;
`else
    assign tx_underrun = 1'b0;
    assign frame_err   = 1'b0;
`endif

    assign miso_oe  = ~ss_s;
    assign miso     = miso_oe ? (lsbfe ? tx_shift[0] : tx_shift[DATA_BITS-1]) : 1'b1;
    assign busy     = active;
    assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Drives spi_slave as an SPI master would, feeds the TX holding register and
// compares every received word, every word seen on miso and the status pulse
// counts against a behavioural model of the slave's word-level behaviour.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int N = 8;
    localparam int H = 8;

`ifdef SPI_SLAVE_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         cpol;
    logic         cpha;
    logic         lsbfe;
    logic         sck;
    logic         ss_n;
    logic         mosi;
    logic         miso;
    logic         miso_oe;
    logic [N-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    logic         tx_underrun;
    logic         frame_err;

    spi_slave #(.DATA_BITS(N), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpol       (cpol),
        .cpha       (cpha),
        .lsbfe      (lsbfe),
        .sck        (sck),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .tx_underrun(tx_underrun),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Observed DUT activity.
    logic [N-1:0] rxQ[$];
    int underCnt = 0;
    int ferrCnt  = 0;

    // Stimulus feed and word-level model of the slave.
    logic [N-1:0] feedQ[$];
    logic [N-1:0] mHold[$];
    int   mUnder = 0;
    int   mFerr  = 0;
    bit   feedEn = 1'b0;
    bit   capNext = 1'b0;

    // Record pulses away from the active edge.
    always @(negedge clk) begin
        if (rx_valid)    rxQ.push_back(rx_data);
        if (tx_underrun) underCnt++;
        if (frame_err)   ferrCnt++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, presenting the head of feedQ to the holding register.
    // A new offer starts only while feedEn is set; an offer already on the bus
    // is held until accepted. Returns 1 time unit after the last posedge.
    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            capNext = 1'b0;
            if (feedQ.size() > 0 && (tx_valid || feedEn)) begin
                tx_valid = 1'b1;
                tx_data  = feedQ[0];
                capNext  = tx_ready;
            end else begin
                tx_valid = 1'b0;
            end
            @(posedge clk);
            if (capNext) mHold.push_back(feedQ.pop_front());
            #1;
        end
    endtask

    // Model: a load takes the held word if any, otherwise the all-ones fill.
    task automatic modelReload(output logic [N-1:0] w);
        if (mHold.size() > 0) begin
            w = mHold.pop_front();
        end else begin
            w = '1;
            mUnder++;
        end
    endtask

    task automatic preload(input logic [N-1:0] w);
        feedQ.push_back(w);
        feedEn = 1'b1;
        for (int g = 0; g < 20 && feedQ.size() > 0; g++) tick(1);
        feedEn = 1'b0;
        checkOutput("preload_accepted", feedQ.size(), 0);
    endtask

    // One master frame of nbits bits. Returns the words the model expects on
    // miso and the words actually read from miso, per word slot.
    task automatic applyStimulus(input bit pol, input bit pha, input bit lsb, input int nbits,
                                 input logic [N-1:0] mw [4],
                                 output logic [N-1:0] expTx [4], output logic [N-1:0] gotTx [4]);
        logic [N-1:0] w;
        logic [N-1:0] cur;
        int i;
        int k;
        for (int j = 0; j < 4; j++) begin
            expTx[j] = '0;
            gotTx[j] = '0;
        end
        cpol = pol; cpha = pha; lsbfe = lsb; sck = pol; feedEn = 1'b0;
        tick(6);
        ss_n = 1'b0;
        modelReload(w);
        expTx[0] = w;
        cur = '0;
        tick(2 * H);
        for (int b = 0; b < nbits; b++) begin
            i = b % N;
            k = b / N;
            feedEn = (i >= 2 && i <= 5);
            if (!pha) begin
                mosi = lsb ? mw[k][i] : mw[k][N-1-i];
                tick(H);
                cur[lsb ? i : N-1-i] = miso;
                sck = ~pol;
                tick(H);
                sck = pol;
                if (i == N-1) begin
                    gotTx[k] = cur;
                    modelReload(w);
                    if (k + 1 < 4) expTx[k+1] = w;
                end
            end else begin
                sck = ~pol;
                if (i == 0 && b != 0) begin
                    modelReload(w);
                    expTx[k] = w;
                end
                mosi = lsb ? mw[k][i] : mw[k][N-1-i];
                tick(H);
                cur[lsb ? i : N-1-i] = miso;
                sck = pol;
                tick(H);
                if (i == N-1) gotTx[k] = cur;
            end
        end
        feedEn = 1'b0;
        tick(H);
        ss_n = 1'b1;
        if (nbits % N != 0) mFerr++;
        tick(3 * H);
    endtask

    task automatic checkRx(input string tag, input int nWords, input logic [N-1:0] mw [4]);
        checkOutput({tag, "_rx_count"}, rxQ.size(), nWords);
        for (int k = 0; k < nWords; k++) begin
            checkOutput($sformatf("%s_rx_word%0d", tag, k), rxQ[k], mw[k]);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"},     busy,        0);
        checkOutput({tag, "_miso_oe"},  miso_oe,     0);
        checkOutput({tag, "_miso"},     miso,        1);
        checkOutput({tag, "_tx_ready"}, tx_ready,    1);
        checkOutput({tag, "_rx_valid"}, rx_valid,    0);
        checkOutput({tag, "_rx_data"},  rx_data,     0);
        checkOutput({tag, "_underrun"}, tx_underrun, 0);
        checkOutput({tag, "_frame_err"}, frame_err,  0);
    endtask

    initial begin
        logic [N-1:0] mw [4];
        logic [N-1:0] expTx [4];
        logic [N-1:0] gotTx [4];
        int u0;
        int f0;
        int nw;
        bit pol;
        bit pha;
        bit lsb;

        rst = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
        tx_valid = 1'b0; tx_data = '0;
        for (int j = 0; j < 4; j++) mw[j] = '0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        tick(4);

        // Mode 0, 0xA5 preloaded, master sends 0x3C.
        $display("[TB] mode 0 single word");
        preload(8'hA5);
        checkOutput("preload_full_tx_ready", tx_ready, 0);
        rxQ.delete();
        mw[0] = 8'h3C;
        applyStimulus(1'b0, 1'b0, 1'b0, N, mw, expTx, gotTx);
        checkOutput("m0_miso_model", gotTx[0], expTx[0]);
        checkOutput("m0_miso_word", gotTx[0], 8'hA5);
        checkRx("m0", 1, mw);

        // Mode 3, LSB first, 3 words with refills between words.
        $display("[TB] mode 3 lsb-first three words");
        preload(8'hC3);
        feedQ.push_back(8'h96);
        feedQ.push_back(8'h5E);
        rxQ.delete();
        mw[0] = 8'h01; mw[1] = 8'h80; mw[2] = 8'hFF;
        applyStimulus(1'b1, 1'b1, 1'b1, 3 * N, mw, expTx, gotTx);
        checkOutput("m3_miso_w0", gotTx[0], 8'hC3);
        checkOutput("m3_miso_w1", gotTx[1], 8'h96);
        checkOutput("m3_miso_w2", gotTx[2], 8'h5E);
        for (int k = 0; k < 3; k++) checkOutput($sformatf("m3_miso_model%0d", k), gotTx[k], expTx[k]);
        checkRx("m3", 3, mw);

        // Empty holding register at frame start: all-ones on miso.
        $display("[TB] underrun frame");
        checkOutput("empty_tx_ready", tx_ready, (mHold.size() == 0) ? 1 : 0);
        u0 = underCnt;
        rxQ.delete();
        mw[0] = N'($urandom);
        applyStimulus(1'b1, 1'b1, 1'b0, N, mw, expTx, gotTx);
        checkOutput("underrun_miso", gotTx[0], 8'hFF);
        checkOutput("underrun_pulses", underCnt - u0, STATUS_EN ? 1 : 0);
        checkRx("underrun", 1, mw);

        // Deselect after 5 bits, then a clean 0x5A frame.
        $display("[TB] partial frame then recovery");
        preload(8'h3A);
        feedQ.push_back(8'hE7);
        f0 = ferrCnt;
        rxQ.delete();
        mw[0] = 8'hB2;
        applyStimulus(1'b0, 1'b0, 1'b0, 5, mw, expTx, gotTx);
        checkOutput("partial_rx_count", rxQ.size(), 0);
        checkOutput("partial_frame_err", ferrCnt - f0, STATUS_EN ? 1 : 0);
        checkOutput("partial_hold_kept", tx_ready, 0);
        mw[0] = 8'h5A;
        applyStimulus(1'b0, 1'b0, 1'b0, N, mw, expTx, gotTx);
        checkOutput("recover_miso", gotTx[0], 8'hE7);
        checkRx("recover", 1, mw);

        // tx_valid held while full; capture only after the reload frees it.
        $display("[TB] held tx_valid");
        preload(8'h69);
        feedQ.push_back(8'h96);
        feedEn = 1'b1;
        tick(10);
        feedEn = 1'b0;
        checkOutput("held_tx_ready", tx_ready, 0);
        checkOutput("held_tx_valid", tx_valid, 1);
        rxQ.delete();
        mw[0] = N'($urandom); mw[1] = N'($urandom);
        applyStimulus(1'b0, 1'b0, 1'b0, 2 * N, mw, expTx, gotTx);
        checkOutput("held_miso_w0", gotTx[0], 8'h69);
        checkOutput("held_miso_w1", gotTx[1], 8'h96);
        checkRx("held", 2, mw);

        // Reset in the middle of a word with the holding register full.
        $display("[TB] reset mid-word");
        preload(8'h11);
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sck = 1'b0;
        tick(6);
        ss_n = 1'b0;
        tick(2 * H);
        feedQ.push_back(8'h22);
        feedEn = 1'b1;
        tick(6);
        feedEn = 1'b0;
        checkOutput("midrst_hold_full", tx_ready, 0);
        rxQ.delete();
        mosi = 1'b1;
        sck = 1'b1; tick(H);
        sck = 1'b0; tick(H);
        sck = 1'b1; tick(H);
        rst = 1'b1; ss_n = 1'b1; sck = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetState("midrst");
        rst = 1'b0;
        mHold.delete();
        tick(10);
        checkOutput("midrst_no_rx", rxQ.size(), 0);

        // Randomised frames against the model.
        $display("[TB] random frames");
        for (int r = 0; r < 4; r++) begin
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            lsb = 1'($urandom_range(0, 1));
            nw  = int'($urandom_range(1, 2));
            for (int k = 0; k < 4; k++) mw[k] = N'($urandom);
            if (mHold.size() == 0 && feedQ.size() == 0) preload(N'($urandom));
            feedQ.push_back(N'($urandom));
            rxQ.delete();
            applyStimulus(pol, pha, lsb, nw * N, mw, expTx, gotTx);
            for (int k = 0; k < nw; k++) begin
                checkOutput($sformatf("rand%0d_miso_w%0d", r, k), gotTx[k], expTx[k]);
            end
            checkRx($sformatf("rand%0d", r), nw, mw);
        end

        checkOutput("underrun_total", underCnt, STATUS_EN ? mUnder : 0);
        checkOutput("frame_err_total", ferrCnt, STATUS_EN ? mFerr : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, bits per SPI word.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on sck/ss_n/mosi (minimum 2).
REQ-003 SHALL have port clk  input  1  main clock; single clock domain for all logic.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port cpol  input  1  SCK idle level; static while ss_n low.
REQ-006 SHALL have port cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-007 SHALL have port lsbfe  input  1  1 = LSB first, 0 = MSB first.
REQ-008 SHALL have port sck  input  1  SPI clock from master, asynchronous.
REQ-009 SHALL have port ss_n  input  1  slave select, active-low, asynchronous.
REQ-010 SHALL have port mosi  input  1  master-out data, asynchronous.
REQ-011 SHALL have port miso  output  1  slave-out data.
REQ-012 SHALL have port miso_oe  output  1  miso drive enable; 1 while selected.
REQ-013 SHALL have port tx_data  input  DATA_BITS  next word to send.
REQ-014 SHALL have port tx_valid  input  1  tx_data valid.
REQ-015 SHALL have port tx_ready  output  1  single-entry TX holding register empty.
REQ-016 SHALL have port rx_data  output  DATA_BITS  last complete received word; held until the next word completes.
REQ-017 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-018 SHALL have port busy  output  1  FSM in ACTIVE.
REQ-019 SHALL have port tx_underrun  output  1  one-cycle status pulse (see REQ-034).
REQ-020 SHALL have port frame_err  output  1  one-cycle status pulse (see REQ-034).

Function
REQ-021 SHALL pass sck, ss_n and mosi through SYNC_STAGES flops; all edge detection uses the synchronised values.
REQ-022 SHALL define leading edge as sck leaving cpol and trailing edge as sck returning to cpol; sample edge = leading if cpha=0, else trailing; shift edge = the other one.
REQ-023 SHALL implement FSM IDLE/ACTIVE: IDLE->ACTIVE on synchronised ss_n falling edge; ACTIVE->IDLE on synchronised ss_n rising edge; busy=1 only in ACTIVE.
REQ-024 SHALL, on entry to ACTIVE, load the shift register from the holding register if full (freeing it, tx_ready=1 next cycle), else with all-ones, and clear the bit counter.
REQ-025 SHALL drive miso from shift-register bit [DATA_BITS-1] (lsbfe=0) or [0] (lsbfe=1); with cpha=0 the first bit is valid on the cycle after ACTIVE entry.
REQ-026 SHALL, on each sample edge in ACTIVE, shift the synchronised mosi into the RX shift register per lsbfe and increment the bit counter.
REQ-027 SHALL, when the counter reaches DATA_BITS, update rx_data and pulse rx_valid on the following cycle, then wrap the counter to 0.
REQ-028 SHALL, on a shift edge after a completed word, reload the TX shift register per REQ-024; otherwise shift it one position. With cpha=1 the first leading edge of a frame SHALL NOT shift.
REQ-029 SHALL set tx_ready = ~holding_full; tx_valid&tx_ready captures tx_data. A capture and a reload in the same cycle SHALL both take effect, with the reload using the old entry.
REQ-030 SHALL discard a partial word on ss_n rise (counter != 0): no rx_valid, holding register untouched, counter cleared.
REQ-031 SHALL drive miso_oe = ~ss_n(synchronised); miso SHALL be 1 while miso_oe=0.
REQ-032 SHALL support sck frequency up to clk/8; faster sck is unsupported.

Reset
REQ-033 SHALL on rst: FSM IDLE, holding register empty (tx_ready=1), shift registers all-ones, counter 0, rx_data 0, rx_valid/busy/tx_underrun/frame_err/miso_oe 0, miso 1, synchronisers 1. A reset mid-frame SHALL abort without rx_valid.

Configuration
REQ-034 SHALL honour macro SPI_SLAVE_STATUS_EN: when defined, tx_underrun pulses when an all-ones fill replaces an empty holding register, and frame_err pulses on an ss_n rise with counter != 0; when undefined, both outputs are constant 0 and their logic is removed.

Verification
REQ-035 SHALL cover: mode 0 (cpol=0,cpha=0,lsbfe=0), tx_data=0xA5 preloaded, master sends 0x3C -> miso carries 0xA5 MSB first; rx_data=0x3C with a single rx_valid pulse.
REQ-036 SHALL cover: mode 3 with lsbfe=1, 3-word frame 0x01,0x80,0xFF, tx refilled between words -> three rx_valid pulses with matching words; miso words match the tx order.
REQ-037 SHALL cover: empty holding register at ss_n fall -> miso=0xFF; tx_underrun pulses once (macro defined) or stays 0 (undefined).
REQ-038 SHALL cover: ss_n rises after 5 bits -> no rx_valid; frame_err pulses once (macro defined); next frame of 0x5A is received correctly.
REQ-039 SHALL cover: rst asserted mid-word -> all outputs at reset values on the next cycle; tx_ready=1.
REQ-040 SHALL cover: tx_valid held while holding full -> no capture until the reload cycle; simultaneous capture+reload preserves both words.
